// File: rtl/axi_master_wrapper_if.sv
// AXI4 master-port bundle (AW/W/B/AR/R) for axi_master_wrapper, with
// master and slave views. Default bus widths are defined here when not already set.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

interface axi_master_wrapper_if;
  logic [`AXI_ID_BITS-1:0]   M_AWID;
  logic [`AXI_ADDR_BITS-1:0] M_AWADDR;
  logic [`AXI_LEN_BITS-1:0]  M_AWLEN;
  logic [2:0]                M_AWSIZE;
  logic [1:0]                M_AWBURST;
  logic                      M_AWVALID;
  logic                      M_AWREADY;
  logic [`AXI_DATA_BITS-1:0] M_WDATA;
  logic [`AXI_STRB_BITS-1:0] M_WSTRB;
  logic                      M_WLAST;
  logic                      M_WVALID;
  logic                      M_WREADY;
  logic [`AXI_ID_BITS-1:0]   M_BID;
  logic [1:0]                M_BRESP;
  logic                      M_BVALID;
  logic                      M_BREADY;
  logic [`AXI_ID_BITS-1:0]   M_ARID;
  logic [`AXI_ADDR_BITS-1:0] M_ARADDR;
  logic [`AXI_LEN_BITS-1:0]  M_ARLEN;
  logic [2:0]                M_ARSIZE;
  logic [1:0]                M_ARBURST;
  logic                      M_ARVALID;
  logic                      M_ARREADY;
  logic [`AXI_ID_BITS-1:0]   M_RID;
  logic [`AXI_DATA_BITS-1:0] M_RDATA;
  logic [1:0]                M_RRESP;
  logic                      M_RLAST;
  logic                      M_RVALID;
  logic                      M_RREADY;

  modport master (
    output M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
    output M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    output M_BREADY,
    output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
    output M_RREADY,
    input  M_AWREADY, M_WREADY, M_BID, M_BRESP, M_BVALID, M_ARREADY,
    input  M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID
  );

  modport slave (
    input  M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
    input  M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    input  M_BREADY,
    input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
    input  M_RREADY,
    output M_AWREADY, M_WREADY, M_BID, M_BRESP, M_BVALID, M_ARREADY,
    output M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID
  );
endinterface

// File: rtl/axi_master_wrapper.sv
// CPU-request to single AXI4 transaction initiator (single-beat write, INCR read burst).
// Optional response checking with cpu_err output: define AXI_MASTER_RESP_CHECK_EN.
module axi_master_wrapper #(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0,
  parameter int                      BURST_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [`AXI_ADDR_BITS-1:0] cpu_addr,
  input  logic [`AXI_DATA_BITS-1:0] cpu_wdata,
  input  logic [`AXI_STRB_BITS-1:0] cpu_wstrb,
  input  logic [`AXI_LEN_BITS-1:0]  cpu_len,
  output logic                      cpu_stall,
  output logic [`AXI_DATA_BITS-1:0] cpu_rdata,
  output logic                      cpu_rvalid,
  output logic                      cpu_done,
  axi_master_wrapper_if.master      m_axi
`ifdef AXI_MASTER_RESP_CHECK_EN
  ,
  output logic                      cpu_err
`endif
);

  localparam logic [`AXI_LEN_BITS-1:0] LEN_MAX = `AXI_LEN_BITS'(BURST_MAX);
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_e;

  state_e                    state_q;
  logic [`AXI_ADDR_BITS-1:0] addr_q;
  logic [`AXI_DATA_BITS-1:0] wdata_q;
  logic [`AXI_STRB_BITS-1:0] wstrb_q;
  logic [`AXI_LEN_BITS-1:0]  len_q;
  logic [`AXI_LEN_BITS-1:0]  beat_q;
  logic                      arvalid_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      rready_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic                      err_q;

  logic ar_hs_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic r_hs_s;
  logic aw_fin_s;
  logic w_fin_s;
  logic r_err_s;
  logic b_err_s;

  assign ar_hs_s  = arvalid_q & m_axi.M_ARREADY;
  assign aw_hs_s  = awvalid_q & m_axi.M_AWREADY;
  assign w_hs_s   = wvalid_q & m_axi.M_WREADY;
  assign b_hs_s   = bready_q & m_axi.M_BVALID;
  assign r_hs_s   = rready_q & m_axi.M_RVALID;
  assign aw_fin_s = aw_done_q | aw_hs_s;
  assign w_fin_s  = w_done_q | w_hs_s;

`ifdef AXI_MASTER_RESP_CHECK_EN
  // A beat counts as bad on a non-OKAY response, a foreign ID, or RLAST at the wrong beat.
  assign r_err_s = r_hs_s & ((m_axi.M_RRESP != 2'b00) | (m_axi.M_RID != MASTER_ID) |
                             (m_axi.M_RLAST & (beat_q != len_q)));
  assign b_err_s = b_hs_s & ((m_axi.M_BRESP != 2'b00) | (m_axi.M_BID != MASTER_ID));
  assign cpu_err = cpu_done & (err_q | r_err_s | b_err_s);
`else
  logic unused_resp_s;
  assign r_err_s       = 1'b0;
  assign b_err_s       = 1'b0;
  assign unused_resp_s = ^{m_axi.M_BID, m_axi.M_BRESP, m_axi.M_RID, m_axi.M_RRESP, err_q};
`endif

  // Stall covers the accept cycle combinationally, then every non-idle cycle.
  assign cpu_stall  = (state_q != S_IDLE) | cpu_req;
  assign cpu_rvalid = r_hs_s;
  assign cpu_rdata  = m_axi.M_RDATA;
  assign cpu_done   = b_hs_s | (r_hs_s & m_axi.M_RLAST);

  assign m_axi.M_AWID    = MASTER_ID;
  assign m_axi.M_AWADDR  = addr_q;
  assign m_axi.M_AWLEN   = '0;
  assign m_axi.M_AWSIZE  = SIZE_WORD;
  assign m_axi.M_AWBURST = BURST_INCR;
  assign m_axi.M_AWVALID = awvalid_q;
  assign m_axi.M_WDATA   = wdata_q;
  assign m_axi.M_WSTRB   = wstrb_q;
  assign m_axi.M_WLAST   = 1'b1;
  assign m_axi.M_WVALID  = wvalid_q;
  assign m_axi.M_BREADY  = bready_q;
  assign m_axi.M_ARID    = MASTER_ID;
  assign m_axi.M_ARADDR  = addr_q;
  assign m_axi.M_ARLEN   = len_q;
  assign m_axi.M_ARSIZE  = SIZE_WORD;
  assign m_axi.M_ARBURST = BURST_INCR;
  assign m_axi.M_ARVALID = arvalid_q;
  assign m_axi.M_RREADY  = rready_q;

  // Transaction FSM with registered VALID/READY outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            wstrb_q   <= cpu_wstrb;
            len_q     <= (cpu_len > LEN_MAX) ? LEN_MAX : cpu_len;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            if (cpu_we) begin
              state_q   <= S_AW_W;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (ar_hs_s) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (r_hs_s) begin
            err_q <= err_q | r_err_s;
            // RLAST alone ends the burst; the counter only feeds the error check.
            if (m_axi.M_RLAST) begin
              beat_q   <= '0;
              rready_q <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              beat_q <= beat_q + `AXI_LEN_BITS'(1);
            end
          end
        end
        S_AW_W: begin
          if (aw_hs_s) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin_s && w_fin_s) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (b_hs_s) begin
            err_q    <= err_q | b_err_s;
            bready_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          arvalid_q <= 1'b0;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_master_wrapper.md
Name: axi_master_wrapper

Overview:
- AXI4 initiator that turns one CPU-side memory request into one AXI transaction: a single-beat write, or a single-beat or INCR burst read.
- Sits between a CPU/cache port and one master port of the AXI bridge, and is the counterpart of the slave-side wrappers.
- Issues AW/W/B or AR/R handshakes, holds the CPU stalled until completion, and returns read beats one by one.

Parameters:
- MASTER_ID, default 0: value driven on M_AWID/M_ARID, `AXI_ID_BITS wide.
- BURST_MAX, default 15: largest cpu_len accepted. Larger values are clamped to BURST_MAX.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  `AXI_ADDR_BITS  byte address, word-aligned.
- cpu_wdata  in  `AXI_DATA_BITS  write data.
- cpu_wstrb  in  `AXI_STRB_BITS  byte enables; a value of 0 is still issued.
- cpu_len  in  `AXI_LEN_BITS  read beats minus 1; ignored for writes.
- cpu_stall  out  1  high while a transaction is outstanding.
- cpu_rdata  out  `AXI_DATA_BITS  read beat data.
- cpu_rvalid  out  1  one-cycle pulse per read beat.
- cpu_done  out  1  one-cycle pulse when the transaction completes.
- M_AW*  out: AWID `AXI_ID_BITS, AWADDR, AWLEN, AWSIZE, AWBURST[1:0], AWVALID.
- M_AWREADY  in  1.
- M_W*  out: WDATA, WSTRB, WLAST, WVALID.
- M_WREADY  in  1.
- M_BID  in  `AXI_ID_BITS.
- M_BRESP  in  2.
- M_BVALID  in  1.
- M_BREADY  out  1.
- M_AR*  out: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID.
- M_ARREADY  in  1.
- M_RID  in  `AXI_ID_BITS.
- M_RDATA  in  `AXI_DATA_BITS.
- M_RRESP  in  2.
- M_RLAST  in  1.
- M_RVALID  in  1.
- M_RREADY  out  1.

Behaviour:
- FSM states: IDLE, AR, R, AW_W, B. Reset puts the FSM in IDLE.
- Reset values: all VALID/READY outputs, cpu_stall, cpu_rvalid, cpu_done = 0; all registers = 0. A reset mid-transaction aborts immediately: VALIDs drop in the next cycle with no completion pulse.
- IDLE with cpu_req=1:
  - Capture addr, wdata, wstrb and len (clamped to BURST_MAX) into registers.
  - Go to AW_W if cpu_we=1, otherwise to AR.
  - cpu_stall is combinationally high in the accept cycle and stays high until the cpu_done cycle, inclusive of neither end beyond that cycle.
- AR:
  - ARVALID=1 with registered fields; ARSIZE=3'b010, ARBURST=INCR, ARLEN=reg_len.
  - Fields are held stable until ARREADY; VALID never drops before the handshake.
  - On ARVALID&ARREADY, go to R.
- R:
  - RREADY=1.
  - Each RVALID&RREADY: cpu_rvalid=1, cpu_rdata=M_RDATA (combinational pass-through), beat counter +1.
  - The beat with RLAST=1 gives cpu_done=1, a counter clear, and a return to IDLE.
  - Completion is decided by RLAST, not by the counter.
- AW_W:
  - AWVALID and WVALID are both asserted on entry; WLAST=1 (single beat); AWLEN=0; AWSIZE=3'b010.
  - Sticky flags aw_done and w_done are set by their own handshakes. Each VALID drops in the cycle after its own handshake.
  - Go to B when both are done; this covers both handshakes in the same cycle and either order.
- B: BREADY=1. On BVALID&BREADY, cpu_done=1 and return to IDLE.
- Response IDs and BRESP/RRESP values are ignored unless the feature below is enabled.
- Back-to-back requests: the earliest next accept is the cycle after cpu_done, since IDLE is re-entered first.
- Minimum latencies with zero-wait slaves:
  - Read: accept at cycle 0, AR handshake at 1, first beat at 2, done at 2+len.
  - Write: accept at 0, AW/W at 1, B at 2.

Optional Feature:
- Macro: AXI_MASTER_RESP_CHECK_EN.
- When defined:
  - Add output cpu_err (1 bit), valid together with cpu_done.
  - cpu_err=1 if any beat's RRESP or BRESP is not OKAY, or any RID/BID differs from MASTER_ID, or RLAST arrives at a beat count different from reg_len+1.
  - Errors are accumulated across the burst and cleared on the next accept.
- When undefined: no cpu_err port, and responses are not examined.

Test Plan:
- Write, zero-wait: cpu_addr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=4'hF -> AWADDR=0x10, WDATA=0xDEADBEEF, WLAST=1 at cycle 1; cpu_done at cycle 2; cpu_stall high in cycles 0-2.
- Write, WREADY before AWREADY: WREADY at cycle 1, AWREADY at cycle 4 -> WVALID low from cycle 2, AWVALID held through cycle 4, BREADY from cycle 5, cpu_done on the B handshake.
- Burst read, len=3: ARLEN=3; 4 beats 0x1..0x4 with RVALID gaps -> cpu_rvalid exactly 4 pulses with matching data; cpu_done together with the RLAST beat.
- ARREADY delayed 5 cycles -> ARADDR/ARLEN/ARVALID stable for all 5 cycles, no R accepted early.
- rst asserted during beat 2 of a len=7 read -> next cycle all outputs 0, FSM in IDLE; a new request accepted normally afterwards.
- With AXI_MASTER_RESP_CHECK_EN: BRESP=2'b10 -> cpu_err=1 with cpu_done; the next good read gives cpu_err=0.
